// File: rtl/frv_mem_arbiter_pkg.sv
// Shared constants for the two-master memory arbiter: requester IDs,
// requester count and the ID width carried through the outstanding-ID FIFO.
package frv_mem_arbiter_pkg;

   localparam int ARB_NREQ = 2;
   localparam int ARB_ID_W = 1;

   localparam logic [ARB_ID_W-1:0] ARB_ID_IMEM = 1'b0;
   localparam logic [ARB_ID_W-1:0] ARB_ID_DMEM = 1'b1;

   typedef logic [ARB_ID_W-1:0] arb_id_t;

   // Pointer width for a FIFO of the given depth; never zero so depth 1 still has a pointer.
   function automatic int arb_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/frv_mem_arb_idfifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered transactions.
// The owner guarantees no push while full and no pop while empty.
module frv_mem_arb_idfifo
   import frv_mem_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    push,
   input  logic    pop,
   input  arb_id_t din,
   output logic    full,
   output logic    empty,
   output arb_id_t head
);

   localparam int PTR_W = arb_ptr_w(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   arb_id_t            mem_r [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_r;
   logic [PTR_W-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]   count_r;

   // Pointer advance with explicit wrap so non-power-of-two pointer ranges stay in bounds.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
   endfunction

   // Storage, pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= ARB_ID_IMEM;
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= ptr_next(wr_ptr_r);
         end
         if (pop) begin
            rd_ptr_r <= ptr_next(rd_ptr_r);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign full  = (count_r == CNT_W'(DEPTH));
   assign empty = (count_r == {CNT_W{1'b0}});
   assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/frv_mem_arbiter.sv
// Shares one memory port between the imem and dmem masters, holding the
// selected requester until granted and routing responses back in grant order.
module frv_mem_arbiter
   import frv_mem_arbiter_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2,
   parameter int DMEM_PRIORITY   = 1
) (
   input  logic        g_clk,
   input  logic        g_reset,
   input  logic [1:0]  rq_req,
   input  logic [1:0]  rq_wen,
   input  logic [7:0]  rq_strb,
   input  logic [63:0] rq_wdata,
   input  logic [63:0] rq_addr,
   output logic [1:0]  rq_gnt,
   output logic [1:0]  rq_recv,
   input  logic [1:0]  rq_ack,
   output logic        rq_error,
   output logic [31:0] rq_rdata,
   output logic        mem_req,
   output logic        mem_wen,
   output logic [3:0]  mem_strb,
   output logic [31:0] mem_wdata,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_recv,
   output logic        mem_ack,
   input  logic        mem_error,
   input  logic [31:0] mem_rdata,
   output logic        arb_err
);

   localparam logic FIXED_PRIO = (DMEM_PRIORITY != 32'sd0);

   arb_id_t    sel_s;
   arb_id_t    head_s;
   logic       full_s;
   logic       empty_s;
   logic       accept_s;
   logic       pop_s;
   logic [1:0] rq_recv_s;
   logic       mem_ack_s;
   logic       lock_r;
   arb_id_t    lock_id_r;
   arb_id_t    rr_last_r;
   logic       arb_err_r;

   // Winner selection; a held lock freezes the choice until the grant.
   always_comb begin
      sel_s = ARB_ID_IMEM;
      if (lock_r) begin
         sel_s = lock_id_r;
      end else if (rq_req == 2'b11) begin
         if (FIXED_PRIO) begin
            sel_s = ARB_ID_DMEM;
         end else begin
            sel_s = ~rr_last_r;
         end
      end else if (rq_req[1]) begin
         sel_s = ARB_ID_DMEM;
      end else begin
         sel_s = ARB_ID_IMEM;
      end
   end

   // Zero-latency payload forwarding from the selected requester.
   always_comb begin
      mem_wen   = rq_wen[0];
      mem_strb  = rq_strb[3:0];
      mem_wdata = rq_wdata[31:0];
      mem_addr  = rq_addr[31:0];
      case (sel_s)
         ARB_ID_DMEM: begin
            mem_wen   = rq_wen[1];
            mem_strb  = rq_strb[7:4];
            mem_wdata = rq_wdata[63:32];
            mem_addr  = rq_addr[63:32];
         end
         default: begin
            mem_wen   = rq_wen[0];
            mem_strb  = rq_strb[3:0];
            mem_wdata = rq_wdata[31:0];
            mem_addr  = rq_addr[31:0];
         end
      endcase
   end

   assign mem_req  = (|rq_req) & ~full_s & ~g_reset;
   assign accept_s = mem_req & mem_gnt;

   // Grant strobe to the selected requester only.
   always_comb begin
      rq_gnt = 2'b00;
      if (accept_s) begin
         rq_gnt[sel_s] = 1'b1;
      end else begin
         rq_gnt = 2'b00;
      end
   end

   // Response steering; with nothing outstanding the response is drained.
   always_comb begin
      rq_recv_s = 2'b00;
      mem_ack_s = 1'b0;
      if (g_reset) begin
         rq_recv_s = 2'b00;
         mem_ack_s = 1'b0;
      end else if (empty_s) begin
         mem_ack_s = 1'b1;
      end else begin
         rq_recv_s[head_s] = mem_recv;
         mem_ack_s         = rq_ack[head_s];
      end
   end

   assign rq_recv  = rq_recv_s;
   assign mem_ack  = mem_ack_s;
   assign pop_s    = mem_recv & mem_ack_s & ~empty_s;
   assign rq_rdata = mem_rdata;
   assign rq_error = mem_error;
   assign arb_err  = arb_err_r & ~g_reset;

   // Lock, round-robin history and sticky protocol-error flag.
   always_ff @(posedge g_clk) begin
      if (g_reset) begin
         lock_r    <= 1'b0;
         lock_id_r <= ARB_ID_IMEM;
         rr_last_r <= ARB_ID_IMEM;
         arb_err_r <= 1'b0;
      end else begin
         if (accept_s) begin
            lock_r    <= 1'b0;
            rr_last_r <= sel_s;
         end else if (mem_req && !lock_r) begin
            lock_r    <= 1'b1;
            lock_id_r <= sel_s;
         end else begin
            lock_r    <= lock_r;
         end
         if (mem_recv && empty_s) begin
            arb_err_r <= 1'b1;
         end else begin
            arb_err_r <= arb_err_r;
         end
      end
   end

   frv_mem_arb_idfifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_idfifo (
      .clk   (g_clk),
      .reset (g_reset),
      .push  (accept_s),
      .pop   (pop_s),
      .din   (sel_s),
      .full  (full_s),
      .empty (empty_s),
      .head  (head_s)
   );

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Directed bench for frv_mem_arbiter: a fixed-priority and a round-robin
// instance driven by the same stimulus, each checked against hand-derived values.
module tb_frv_mem_arbiter;

   logic        g_clk = 1'b0;
   logic        g_reset;
   logic [1:0]  rq_req;
   logic [1:0]  rq_wen;
   logic [7:0]  rq_strb;
   logic [63:0] rq_wdata;
   logic [63:0] rq_addr;
   logic [1:0]  rq_ack;
   logic        mem_gnt;
   logic        mem_recv;
   logic        mem_error;
   logic [31:0] mem_rdata;

   logic [1:0]  p_gnt,   r_gnt;
   logic [1:0]  p_recv,  r_recv;
   logic        p_error, r_error;
   logic [31:0] p_rdata, r_rdata;
   logic        p_req,   r_req;
   logic        p_wen,   r_wen;
   logic [3:0]  p_strb,  r_strb;
   logic [31:0] p_wdata, r_wdata;
   logic [31:0] p_addr,  r_addr;
   logic        p_ack,   r_ack;
   logic        p_err,   r_err;

   int checks = 0;
   int errors = 0;

   always #5 g_clk = ~g_clk;

   frv_mem_arbiter #(.MAX_OUTSTANDING(2), .DMEM_PRIORITY(1)) u_prio (
      .g_clk(g_clk), .g_reset(g_reset),
      .rq_req(rq_req), .rq_wen(rq_wen), .rq_strb(rq_strb), .rq_wdata(rq_wdata),
      .rq_addr(rq_addr), .rq_gnt(p_gnt), .rq_recv(p_recv), .rq_ack(rq_ack),
      .rq_error(p_error), .rq_rdata(p_rdata),
      .mem_req(p_req), .mem_wen(p_wen), .mem_strb(p_strb), .mem_wdata(p_wdata),
      .mem_addr(p_addr), .mem_gnt(mem_gnt), .mem_recv(mem_recv), .mem_ack(p_ack),
      .mem_error(mem_error), .mem_rdata(mem_rdata), .arb_err(p_err)
   );

   frv_mem_arbiter #(.MAX_OUTSTANDING(2), .DMEM_PRIORITY(0)) u_rr (
      .g_clk(g_clk), .g_reset(g_reset),
      .rq_req(rq_req), .rq_wen(rq_wen), .rq_strb(rq_strb), .rq_wdata(rq_wdata),
      .rq_addr(rq_addr), .rq_gnt(r_gnt), .rq_recv(r_recv), .rq_ack(rq_ack),
      .rq_error(r_error), .rq_rdata(r_rdata),
      .mem_req(r_req), .mem_wen(r_wen), .mem_strb(r_strb), .mem_wdata(r_wdata),
      .mem_addr(r_addr), .mem_gnt(mem_gnt), .mem_recv(mem_recv), .mem_ack(r_ack),
      .mem_error(mem_error), .mem_rdata(mem_rdata), .arb_err(r_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then settle combinational outputs away from the edge.
   task automatic tick();
      @(posedge g_clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      g_reset   = 1'b1;
      rq_req    = 2'b11;
      rq_wen    = 2'b10;
      rq_strb   = 8'hF3;
      rq_wdata  = {32'hDDDD_0001, 32'h1111_0000};
      rq_addr   = 64'd0;
      rq_ack    = 2'b00;
      mem_gnt   = 1'b1;
      mem_recv  = 1'b1;
      mem_error = 1'b0;
      mem_rdata = 32'd0;
      tick();
      tick();
      chk("rst_mem_req", 32'(p_req), 32'd0);
      chk("rst_gnt", 32'(p_gnt), 32'd0);
      chk("rst_recv", 32'(p_recv), 32'd0);
      chk("rst_ack", 32'(p_ack), 32'd0);
      chk("rst_arb_err", 32'(p_err), 32'd0);
      rq_req   = 2'b00;
      mem_gnt  = 1'b0;
      mem_recv = 1'b0;
      tick();
      g_reset = 1'b0;
      tick();

      // Single imem transaction.
      rq_req  = 2'b01;
      rq_addr = {32'h0000_0000, 32'h8000_0000};
      mem_gnt = 1'b1;
      settle();
      chk("t1_gnt", 32'(p_gnt), 32'h1);
      chk("t1_addr", p_addr, 32'h8000_0000);
      chk("t1_wdata", p_wdata, 32'h1111_0000);
      tick();
      rq_req    = 2'b00;
      mem_gnt   = 1'b0;
      mem_recv  = 1'b1;
      mem_rdata = 32'h0000_0013;
      mem_error = 1'b1;
      rq_ack    = 2'b01;
      settle();
      chk("t1_recv", 32'(p_recv), 32'h1);
      chk("t1_rdata", p_rdata, 32'h0000_0013);
      chk("t1_error", 32'(p_error), 32'h1);
      chk("t1_ack", 32'(p_ack), 32'h1);
      tick();
      mem_recv  = 1'b0;
      mem_error = 1'b0;
      rq_ack    = 2'b00;
      settle();
      chk("t1_empty_ack", 32'(p_ack), 32'h1);
      chk("t1_no_err", 32'(p_err), 32'h0);

      // Simultaneous requests under fixed dmem priority.
      rq_req  = 2'b11;
      rq_addr = {32'hB000_0000, 32'hA000_0000};
      mem_gnt = 1'b1;
      settle();
      chk("t2_gnt_d", 32'(p_gnt), 32'h2);
      chk("t2_addr_d", p_addr, 32'hB000_0000);
      chk("t2_wen_d", 32'(p_wen), 32'h1);
      chk("t2_strb_d", 32'(p_strb), 32'hF);
      tick();
      rq_req = 2'b01;
      settle();
      chk("t2_gnt_i", 32'(p_gnt), 32'h1);
      chk("t2_addr_i", p_addr, 32'hA000_0000);
      tick();
      rq_req   = 2'b00;
      mem_gnt  = 1'b0;
      mem_recv = 1'b1;
      rq_ack   = 2'b11;
      settle();
      chk("t2_recv0", 32'(p_recv), 32'h2);
      tick();
      settle();
      chk("t2_recv1", 32'(p_recv), 32'h1);
      tick();
      mem_recv = 1'b0;
      rq_ack   = 2'b00;

      // Round robin with both requesting continuously for four grants.
      rq_req  = 2'b11;
      mem_gnt = 1'b1;
      settle();
      chk("t3_rr_g0", 32'(r_gnt), 32'h2);
      chk("t3_fp_g0", 32'(p_gnt), 32'h2);
      tick();
      mem_recv = 1'b1;
      rq_ack   = 2'b11;
      settle();
      chk("t3_rr_g1", 32'(r_gnt), 32'h1);
      chk("t3_rr_recv", 32'(r_recv), 32'h2);
      chk("t3_fp_g1", 32'(p_gnt), 32'h2);
      tick();
      settle();
      chk("t3_rr_g2", 32'(r_gnt), 32'h2);
      chk("t3_rr_recv2", 32'(r_recv), 32'h1);
      tick();
      settle();
      chk("t3_rr_g3", 32'(r_gnt), 32'h1);
      tick();
      rq_req  = 2'b00;
      mem_gnt = 1'b0;
      settle();
      chk("t3_rr_recv_last", 32'(r_recv), 32'h1);
      tick();
      mem_recv = 1'b0;
      rq_ack   = 2'b00;

      // Lock holds imem while the grant is withheld.
      rq_req  = 2'b01;
      rq_addr = {32'h0000_2000, 32'h0000_1000};
      settle();
      chk("t4_req", 32'(p_req), 32'h1);
      chk("t4_addr_c1", p_addr, 32'h0000_1000);
      chk("t4_gnt_c1", 32'(p_gnt), 32'h0);
      tick();
      rq_req = 2'b11;
      settle();
      chk("t4_addr_c2", p_addr, 32'h0000_1000);
      tick();
      settle();
      chk("t4_addr_c3", p_addr, 32'h0000_1000);
      tick();
      mem_gnt = 1'b1;
      settle();
      chk("t4_gnt_i", 32'(p_gnt), 32'h1);
      chk("t4_addr_i", p_addr, 32'h0000_1000);
      tick();
      rq_req = 2'b10;
      settle();
      chk("t4_gnt_d", 32'(p_gnt), 32'h2);
      chk("t4_addr_d", p_addr, 32'h0000_2000);
      tick();

      // Two outstanding: requests blocked until a response is acknowledged.
      rq_req = 2'b11;
      settle();
      chk("t5_full_req", 32'(p_req), 32'h0);
      chk("t5_full_gnt", 32'(p_gnt), 32'h0);
      mem_recv = 1'b1;
      rq_ack   = 2'b00;
      settle();
      chk("t5_recv_c1", 32'(p_recv), 32'h1);
      chk("t5_ack_c1", 32'(p_ack), 32'h0);
      tick();
      settle();
      chk("t5_recv_c2", 32'(p_recv), 32'h1);
      chk("t5_ack_c2", 32'(p_ack), 32'h0);
      chk("t5_req_c2", 32'(p_req), 32'h0);
      tick();
      rq_ack = 2'b01;
      settle();
      chk("t5_ack_c3", 32'(p_ack), 32'h1);
      chk("t5_req_c3", 32'(p_req), 32'h0);
      tick();
      mem_recv = 1'b0;
      mem_gnt  = 1'b0;
      settle();
      chk("t5_req_after_pop", 32'(p_req), 32'h1);
      rq_req   = 2'b00;
      mem_recv = 1'b1;
      rq_ack   = 2'b10;
      settle();
      chk("t5_recv_d", 32'(p_recv), 32'h2);
      tick();
      mem_recv = 1'b0;
      rq_ack   = 2'b00;

      // Response with nothing outstanding.
      mem_recv = 1'b1;
      settle();
      chk("t6_ack", 32'(p_ack), 32'h1);
      chk("t6_recv", 32'(p_recv), 32'h0);
      tick();
      mem_recv = 1'b0;
      settle();
      chk("t6_err_set", 32'(p_err), 32'h1);
      chk("t6_rr_err_set", 32'(r_err), 32'h1);
      tick();
      tick();
      chk("t6_err_sticky", 32'(p_err), 32'h1);
      g_reset = 1'b1;
      settle();
      chk("t6_err_in_rst", 32'(p_err), 32'h0);
      tick();
      g_reset = 1'b0;
      tick();
      chk("t6_err_cleared", 32'(p_err), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frv_mem_arbiter.md
Name: frv_mem_arbiter

Overview:
Shares one external memory port between the core's two request/grant/receive/acknowledge bus masters: the instruction-fetch port and the load/store port. It sits between the core's imem_*/dmem_* buses and a single-ported memory or interconnect. It arbitrates requests, holds the winner stable until granted, and tracks outstanding transactions in an in-order ID FIFO. It routes each response back to the requester that issued it.

Parameters:
MAX_OUTSTANDING, 2, depth of the ID FIFO; power of two, 1..4; the maximum number of granted requests still awaiting a response.
DMEM_PRIORITY, 1, 1 means fixed priority to requester 1 (dmem); 0 means two-way round robin.

Ports:
g_clk  in  1  global clock
g_reset  in  1  synchronous reset, active-high
rq_req  in  2  per-requester request; bit0 = imem, bit1 = dmem
rq_wen  in  2  per-requester write enable
rq_strb  in  8  per-requester write strobe, [4i+3:4i]
rq_wdata  in  64  per-requester write data, [32i+31:32i]
rq_addr  in  64  per-requester address, [32i+31:32i]
rq_gnt  out  2  per-requester request accepted
rq_recv  out  2  per-requester response valid
rq_ack  in  2  per-requester response acknowledge
rq_error  out  1  response error, broadcast; qualified by rq_recv
rq_rdata  out  32  response read data, broadcast; qualified by rq_recv
mem_req  out  1  downstream request
mem_wen  out  1  downstream write enable
mem_strb  out  4  downstream strobe
mem_wdata  out  32  downstream write data
mem_addr  out  32  downstream address
mem_gnt  in  1  downstream request accepted
mem_recv  in  1  downstream response valid
mem_ack  out  1  downstream response acknowledge
mem_error  in  1  downstream response error
mem_rdata  in  32  downstream read data
arb_err  out  1  sticky protocol-violation flag

Behaviour:
- Clock is g_clk. Reset is synchronous and active-high on g_reset. While g_reset is high, all of rq_gnt, rq_recv, mem_req, mem_ack and arb_err are 0. On the cycle after reset: FIFO empty, lock clear, round-robin pointer = 0 (imem last served, so dmem wins the first tie), arb_err = 0.
- Handshakes:
  - Request accepted on the same cycle that mem_req & mem_gnt are both high.
  - Response accepted on the same cycle that mem_recv & mem_ack are both high.
  - Requesters hold req and payload until gnt. The arbiter forwards the winner's payload combinationally, with zero added latency.
- Selection:
  - Lock register clear:
    - Only one request → that requester wins.
    - Both requesting → dmem wins if DMEM_PRIORITY=1, otherwise the requester not served last wins.
  - Lock register set: it holds the selected ID from the first cycle mem_req is asserted without mem_gnt until the grant. No re-arbitration occurs while the lock is set, even if a higher-priority request arrives.
- mem_req = (|rq_req) & !fifo_full.
- rq_gnt[sel] = mem_req & mem_gnt; the other bit is 0.
- On acceptance: push sel to the FIFO, clear the lock, and update the round-robin pointer to sel.
- Full is evaluated on the registered count only. A push in the same cycle as a pop while full is not possible, because mem_req is masked. Simultaneous push and pop when not full leaves the count unchanged.
- Response routing:
  - head = FIFO head ID.
  - rq_recv[head] = mem_recv & !empty.
  - mem_ack = empty ? 1 : rq_ack[head].
  - Pop on mem_recv & mem_ack & !empty.
  - rq_rdata and rq_error pass mem_rdata and mem_error through combinationally.
- Responses return strictly in grant order. A same-cycle grant and response is legal; the response goes to the older entry.
- mem_recv while the FIFO is empty: protocol violation. The response is drained (mem_ack = 1), no rq_recv is raised, and arb_err is set, staying set until reset.
- Reset mid-transaction: the FIFO, lock and pointer are discarded. Responses that arrive afterwards fall under the empty-FIFO rule.

Decomposition:
- Shared header constants: ARB_ID_IMEM = 1'b0, ARB_ID_DMEM = 1'b1, ARB_NREQ = 2, and the ID width.
- Sub-module frv_mem_arb_idfifo: a synchronous FIFO of 1-bit IDs, parameterised by depth, with push/pop/full/empty/head outputs and a synchronous active-high reset.

Test Plan:
- Reset, then imem req with addr 0x8000_0000 and mem_gnt=1 → rq_gnt=2'b01 the same cycle. mem_recv with rdata 0x0000_0013 → rq_recv=2'b01, rq_rdata=0x13, FIFO returns to empty.
- Both requesting, DMEM_PRIORITY=1, mem_gnt=1 → dmem granted first; imem granted the next cycle; responses return on rq_recv 2'b10 then 2'b01.
- DMEM_PRIORITY=0, both requesting continuously for 4 grants → grant order dmem, imem, dmem, imem.
- mem_gnt=0 for 3 cycles with imem selected, dmem raises req in cycle 2 → mem_addr stays at imem's address until the grant, then dmem is served.
- MAX_OUTSTANDING=2, two grants, no mem_recv → mem_req=0 despite requests. One mem_recv with rq_ack held 0 for 2 cycles → no pop, mem_ack=0, mem_req stays 0 until the ack.
- mem_recv=1 with the FIFO empty → mem_ack=1, rq_recv=0, arb_err=1 until g_reset.
